// File: rtl/ldq_violation_detect.sv
// rtl/ldq_violation_detect.sv - memory-order violation detect on store address resolution
// Picks the oldest executed, address-matching load younger than the resolving store.
module ldq_violation_detect #(
  parameter int DEPTH = 16,
  parameter int INDEX = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             stValid_i,
  input  logic [DEPTH-1:0] matchVect_i,
  input  logic [INDEX-1:0] stLdqPtr_i,
  input  logic [INDEX-1:0] ldqTail_i,
  input  logic             ldqFull_i,
  input  logic             ldExec_i,
  input  logic [INDEX-1:0] ldExecIdx_i,
  input  logic             ldAlloc_i,
  input  logic [INDEX-1:0] ldAllocIdx_i,
  output logic             violation_o,
  output logic [INDEX-1:0] violIdx_o
);

  logic [DEPTH-1:0] exec_q;
  logic [DEPTH-1:0] exec_d;
  logic [DEPTH-1:0] young;
  logic [DEPTH-1:0] exec_view;
  logic [DEPTH-1:0] elig;
  logic [DEPTH-1:0] rot;
  logic [INDEX-1:0] span;
  logic [INDEX-1:0] off;
  logic [INDEX-1:0] src;
  logic [INDEX-1:0] rot_idx;
  logic [INDEX-1:0] sel_idx;
  logic             hit;

  // Allocation is applied after execute so a same-index collision ends cleared.
  always_comb begin
    exec_d = exec_q;
    if (ldExec_i)  exec_d[ldExecIdx_i]  = 1'b1;
    if (ldAlloc_i) exec_d[ldAllocIdx_i] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      exec_q <= '0;
    end else begin
      exec_q <= exec_d;
    end
  end

  always_comb begin
    young = '0;
    off   = '0;
    src   = '0;
    rot   = '0;
    span  = ldqTail_i - stLdqPtr_i;
    // Distance from the store pointer, modulo DEPTH, handles wrap-around without case splits.
    for (int i = 0; i < DEPTH; i++) begin
      off      = INDEX'(i) - stLdqPtr_i;
      young[i] = (off < span) || ((span == '0) && ldqFull_i);
    end

    // Same-cycle execute is bypassed in: that load already read stale data.
    exec_view = exec_q | (ldExec_i ? (DEPTH'(1) << ldExecIdx_i) : '0);
    elig      = stValid_i ? (matchVect_i & exec_view & young) : '0;

    for (int k = 0; k < DEPTH; k++) begin
      src    = INDEX'(k) + stLdqPtr_i;
      rot[k] = elig[src];
    end

    rot_idx = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (rot[k]) rot_idx = INDEX'(k);
    end
    hit     = |elig;
    sel_idx = rot_idx + stLdqPtr_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      violation_o <= 1'b0;
      violIdx_o   <= '0;
    end else begin
      violation_o <= hit && !flush_i;
      if (hit && !flush_i) violIdx_o <= sel_idx;
    end
  end

endmodule
